// File: rtl/store_result_checker.sv
// Memory-side store checker: watches processor stores into a result window and checks them in order
// against an expected table. Optional build macro STORE_CHK_IGNORE_OOW_EN ignores out-of-window stores.
module store_result_checker #(
  parameter logic [31:0] BASE_ADDR      = 32'd100,
  parameter int          NUM_CHECKS     = 4,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        exp_we,
  input  logic [3:0]  exp_idx,
  input  logic [31:0] exp_data,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic        done,
  output logic        pass,
  output logic [2:0]  fail_code,
  output logic [3:0]  fail_idx,
  output logic [4:0]  checked_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_PASS, ST_FAIL} state_e;

  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] WIN_END  = BASE_ADDR + 32'(4 * NUM_CHECKS);
  localparam logic [4:0]  CNT_LAST = 5'(NUM_CHECKS - 1);

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_DATA     = 3'd1;
  localparam logic [2:0] CODE_WINDOW   = 3'd2;
  localparam logic [2:0] CODE_ORDER    = 3'd3;
  localparam logic [2:0] CODE_TIMEOUT  = 3'd4;
  localparam logic [2:0] CODE_MISALIGN = 3'd5;

  // Power-on contents of the expected table (results of the default FP vector program)
  function automatic logic [31:0] reset_entry(input int k);
    logic [31:0] v;
    case (k)
      0:       v = 32'h4585_E600;
      1:       v = 32'h45C8_C700;
      2:       v = 32'h0000_4040;
      3:       v = 32'h0000_3A80;
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  state_e        state_q, state_d;
  logic [31:0]   tab_q [NUM_CHECKS];
  logic [31:0]   tab_d [NUM_CHECKS];
  logic [4:0]    cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [2:0]    code_q, code_d;
  logic [3:0]    idx_q, idx_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic          in_win_s;
  logic          misal_s;
  logic [3:0]    slot_s;
  logic [31:0]   exp_word_s;
  logic          st_ok_s;
  logic          st_fail_s;
  logic [2:0]    st_code_s;
  logic [3:0]    st_idx_s;

  assign in_win_s = (Adr >= BASE_ADDR) && (Adr < WIN_END);
  assign misal_s  = (Adr[1:0] != 2'b00);
  assign slot_s   = 4'((Adr - BASE_ADDR) >> 2);

  // Expected word for the slot addressed by the current store
  always_comb begin
    exp_word_s = 32'h0000_0000;
    for (int k = 0; k < NUM_CHECKS; k++) begin
      if (slot_s == 4'(k)) begin
        exp_word_s = tab_q[k];
      end else begin
        exp_word_s = exp_word_s;
      end
    end
  end

  // Classify the store on the bus; priority misaligned > window > order > data
  always_comb begin
    st_ok_s   = 1'b0;
    st_fail_s = 1'b0;
    st_code_s = CODE_NONE;
    st_idx_s  = 4'd0;
    if (MemWrite) begin
`ifdef STORE_CHK_IGNORE_OOW_EN
      if (!in_win_s) begin
        st_ok_s = 1'b0;
      end else if (misal_s) begin
`else
      if (misal_s) begin
`endif
        st_fail_s = 1'b1;
        st_code_s = CODE_MISALIGN;
      end else if (!in_win_s) begin
        st_fail_s = 1'b1;
        st_code_s = CODE_WINDOW;
      end else if ({1'b0, slot_s} != cnt_q) begin
        st_fail_s = 1'b1;
        st_code_s = CODE_ORDER;
        st_idx_s  = slot_s;
      end else if (WriteData != exp_word_s) begin
        st_fail_s = 1'b1;
        st_code_s = CODE_DATA;
        st_idx_s  = slot_s;
      end else begin
        st_ok_s = 1'b1;
      end
    end else begin
      st_ok_s = 1'b0;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    tab_d   = tab_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    code_d  = code_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (exp_we) begin
          for (int k = 0; k < NUM_CHECKS; k++) begin
            if (exp_idx == 4'(k)) begin
              tab_d[k] = exp_data;
            end else begin
              tab_d[k] = tab_q[k];
            end
          end
        end else begin
          tab_d = tab_q;
        end
        if (start) begin
          state_d = ST_ARMED;
          to_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (st_fail_s) begin
          state_d = ST_FAIL;
          code_d  = st_code_s;
          idx_d   = st_idx_s;
        end else if (st_ok_s) begin
          // an accepted store also beats a timeout on the same edge
          cnt_d = cnt_q + 5'd1;
          to_d  = '0;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_PASS;
          end else begin
            state_d = ST_ARMED;
          end
        end else if (to_q == TO_LAST) begin
          state_d = ST_FAIL;
          code_d  = CODE_TIMEOUT;
          idx_d   = 4'd0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      ST_PASS:  state_d = ST_PASS;
      ST_FAIL:  state_d = ST_FAIL;
      default:  state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_PASS) || (state_d == ST_FAIL);
    pass_d = (state_d == ST_PASS);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < NUM_CHECKS; k++) begin
        tab_q[k] <= reset_entry(k);
      end
      cnt_q  <= 5'd0;
      to_q   <= '0;
      code_q <= CODE_NONE;
      idx_q  <= 4'd0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tab_q   <= tab_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign done          = done_q;
  assign pass          = pass_q;
  assign fail_code     = code_q;
  assign fail_idx      = idx_q;
  assign checked_count = cnt_q;

endmodule

// File: tb/tb_store_result_checker.sv
// Randomized bench for store_result_checker against a behavioural model of the checking rules.
module tb_store_result_checker;

  localparam logic [31:0] BASE = 32'd100;
  localparam int          N    = 4;
  localparam int          TO   = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        exp_we;
  logic [3:0]  exp_idx;
  logic [31:0] exp_data;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic        done;
  logic        pass;
  logic [2:0]  fail_code;
  logic [3:0]  fail_idx;
  logic [4:0]  checked_count;

  int n_tests = 0;
  int n_fail  = 0;

  // model: 0 idle, 1 armed, 2 pass, 3 fail
  int          m_state;
  logic [31:0] m_tab [16];
  int          m_cnt, m_to, m_code, m_idx;

  store_result_checker #(.BASE_ADDR(BASE), .NUM_CHECKS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_data(exp_data), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .done(done), .pass(pass), .fail_code(fail_code), .fail_idx(fail_idx),
    .checked_count(checked_count)
  );

  always #5 clk = ~clk;

  logic [31:0] dut_vec;
  assign dut_vec = {18'd0, done, pass, fail_code, fail_idx, checked_count};

  function automatic logic [31:0] pack(input logic d, input logic p, input int c, input int i, input int n);
    return {18'd0, d, p, 3'(c), 4'(i), 5'(n)};
  endfunction

  function automatic logic [31:0] mdl_vec();
    return pack(m_state >= 2, m_state == 2, m_code, m_idx, m_cnt);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (d,p,code,idx,cnt packed) at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_to = 0; m_code = 0; m_idx = 0;
    for (int k = 0; k < 16; k++) m_tab[k] = 32'h0;
    m_tab[0] = 32'h4585_E600;
    m_tab[1] = 32'h45C8_C700;
    m_tab[2] = 32'h0000_4040;
    m_tab[3] = 32'h0000_3A80;
  endtask

  task automatic model_fail(input int code, input int idx);
    m_state = 3; m_code = code; m_idx = idx;
  endtask

  // One clock edge of the checking rules, applied to the inputs present at that edge
  task automatic model_edge();
    longint a;
    bit     inwin, acc, ignore;
    int     slot;
    acc = 0;
    if (m_state == 0) begin
      if (exp_we && exp_idx < N) m_tab[exp_idx] = exp_data;
      if (start) begin m_state = 1; m_to = 0; end
    end else if (m_state == 1) begin
      if (MemWrite) begin
        a      = longint'(Adr);
        inwin  = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * N);
`ifdef STORE_CHK_IGNORE_OOW_EN
        ignore = !inwin;
`else
        ignore = 0;
`endif
        if (!ignore) begin
          if (a % 4 != 0) model_fail(5, 0);
          else if (!inwin) model_fail(2, 0);
          else begin
            slot = int'((a - longint'(BASE)) / 4);
            if (slot != m_cnt) model_fail(3, slot);
            else if (WriteData != m_tab[slot]) model_fail(1, slot);
            else acc = 1;
          end
        end
      end
      if (acc) begin
        m_cnt++; m_to = 0;
        if (m_cnt == N) m_state = 2;
      end else if (m_state == 1) begin
        m_to++;
        if (m_to == TO) model_fail(4, 0);
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk(tag, dut_vec, mdl_vec());
    start = 1'b0; exp_we = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input string tag);
    MemWrite = 1'b1; Adr = a; WriteData = d;
    step(tag);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1 model_reset();
    chk("async_reset", dut_vec, mdl_vec());
    #2 reset = 1'b1;
  endtask

  initial begin
    int choice;
    logic [31:0] a;
    reset = 1'b0; start = 1'b0; exp_we = 1'b0; exp_idx = 4'd0; exp_data = 32'h0;
    MemWrite = 1'b0; Adr = 32'h0; WriteData = 32'h0;
    #3 model_reset();
    chk("reset_state", dut_vec, pack(0, 0, 0, 0, 0));
    #3 reset = 1'b1;

    // full passing sequence
    start = 1'b1; step("start");
    store(32'd100, 32'h4585_E600, "pass_s0");
    store(32'd104, 32'h45C8_C700, "pass_s1");
    store(32'd108, 32'h0000_4040, "pass_s2");
    store(32'd112, 32'h0000_3A80, "pass_s3");
    chk("pass_final", dut_vec, pack(1, 1, 0, 0, 4));
    store(32'd100, 32'h0, "pass_sticky");

    // data mismatch on slot 2
    do_reset();
    start = 1'b1; step("start");
    store(32'd100, 32'h4585_E600, "mm_s0");
    store(32'd104, 32'h45C8_C700, "mm_s1");
    store(32'd108, 32'h0000_4041, "mm_s2");
    chk("mismatch", dut_vec, pack(1, 0, 1, 2, 2));

    // out-of-order first store
    do_reset();
    start = 1'b1; step("start");
    store(32'd104, 32'h45C8_C700, "ooo");
    chk("out_of_order", dut_vec, pack(1, 0, 3, 1, 0));

    // out-of-window first store
    do_reset();
    start = 1'b1; step("start");
    store(32'd200, 32'h4585_E600, "oow");
`ifdef STORE_CHK_IGNORE_OOW_EN
    chk("out_of_window", dut_vec, pack(0, 0, 0, 0, 0));
`else
    chk("out_of_window", dut_vec, pack(1, 0, 2, 0, 0));
`endif

    // misaligned in-window store
    do_reset();
    start = 1'b1; step("start");
    store(32'd101, 32'h4585_E600, "misal");
    chk("misaligned", dut_vec, pack(1, 0, 5, 0, 0));

    // table rewrite in IDLE, then match
    do_reset();
    exp_we = 1'b1; exp_idx = 4'd0; exp_data = 32'hDEAD_BEEF; step("expw");
    exp_we = 1'b1; exp_idx = 4'd9; exp_data = 32'h1111_1111; step("expw_oob");
    start = 1'b1; step("start");
    store(32'd100, 32'hDEAD_BEEF, "newtab");
    chk("new_table", dut_vec, pack(0, 0, 0, 0, 1));
    do_reset();
    exp_we = 1'b1; exp_idx = 4'd0; exp_data = 32'hDEAD_BEEF; step("expw");
    start = 1'b1; step("start");
    store(32'd100, 32'h4585_E600, "oldval");
    chk("old_value", dut_vec, pack(1, 0, 1, 0, 0));

    // start and exp_we in the same cycle: write then arm
    do_reset();
    start = 1'b1; exp_we = 1'b1; exp_idx = 4'd1; exp_data = 32'h1234_5678; step("start_we");
    store(32'd100, 32'h4585_E600, "sw_s0");
    store(32'd104, 32'h1234_5678, "sw_s1");
    chk("start_with_we", dut_vec, pack(0, 0, 0, 0, 2));

    // timeout exactly after TO idle armed cycles
    do_reset();
    start = 1'b1; step("start");
    for (int c = 0; c < TO - 1; c++) step("to_wait");
    chk("to_not_yet", dut_vec, pack(0, 0, 0, 0, 0));
    step("to_edge");
    chk("timeout", dut_vec, pack(1, 0, 4, 0, 0));

    // accepted store on the terminal cycle
    do_reset();
    start = 1'b1; step("start");
    for (int c = 0; c < TO - 1; c++) step("to2_wait");
    store(32'd100, 32'h4585_E600, "to2_store");
    chk("to_rescued", dut_vec, pack(0, 0, 0, 0, 1));

    // reset mid-run, then stores in IDLE are ignored
    do_reset();
    start = 1'b1; step("start");
    store(32'd100, 32'h4585_E600, "mid_s0");
    store(32'd104, 32'h45C8_C700, "mid_s1");
    do_reset();
    chk("mid_reset", dut_vec, pack(0, 0, 0, 0, 0));
    store(32'd100, 32'h4585_E600, "idle_store");
    chk("idle_ignored", dut_vec, pack(0, 0, 0, 0, 0));

    // randomized runs
    for (int r = 0; r < 80; r++) begin
      do_reset();
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        exp_we = 1'b1; exp_idx = 4'($urandom_range(0, 7)); exp_data = $urandom;
        if ($urandom_range(0, 3) == 0) begin
          MemWrite = 1'b1; Adr = BASE; WriteData = $urandom;
        end
        step("rnd_idle");
      end
      start = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        exp_we = 1'b1; exp_idx = 4'($urandom_range(0, 3)); exp_data = $urandom;
      end
      step("rnd_start");
      for (int c = 0; c < 40 && m_state == 1; c++) begin
        choice = int'($urandom_range(0, 19));
        if (choice < 12) begin
          MemWrite = 1'b1; Adr = BASE + 32'(4 * m_cnt); WriteData = m_tab[m_cnt];
        end else if (choice < 14) begin
          MemWrite = 1'b0;
        end else if (choice < 16) begin
          MemWrite = 1'b1; Adr = BASE + 32'(4 * m_cnt);
          WriteData = m_tab[m_cnt] ^ (32'h1 << $urandom_range(0, 31));
        end else if (choice < 18) begin
          MemWrite = 1'b1; Adr = BASE + 32'(4 * $urandom_range(0, N - 1)); WriteData = $urandom;
        end else begin
          a = 32'd90 + 32'($urandom_range(0, 36));
          MemWrite = 1'b1; Adr = a; WriteData = $urandom;
        end
        step("rnd_armed");
      end
      for (int c = 0; c < 2; c++) begin
        MemWrite = 1'b1; Adr = BASE; WriteData = m_tab[0]; start = 1'b1;
        step("rnd_after");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
